// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
// Contents:
//   state_t  - sequencer state encoding
//   trap_t   - halt cause codes driven on trap_cause
//   OPC_*    - RV32I 7-bit major opcodes shared with the instruction decoder
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        TRAP_NONE     = 3'd0,
        TRAP_ECALL    = 3'd1,
        TRAP_EBREAK   = 3'd2,
        TRAP_ILLEGAL  = 3'd3,
        TRAP_MISALIGN = 3'd4
    } trap_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/cpu_perf_counters.sv
// Cycle and retired-instruction counters. Both wrap at 2^XLEN.
// Ports:
//   clk, reset     - core clock, synchronous active-high reset
//   cycle_en       - count this cycle
//   instret_en     - one instruction retired this cycle
//   cycle_count    - cycles counted since reset
//   instret_count  - instructions retired since reset
module cpu_perf_counters #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cycle_en,
    input  logic            instret_en,
    output logic [XLEN-1:0] cycle_count,
    output logic [XLEN-1:0] instret_count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (cycle_en)   cycle_count   <= cycle_count + XLEN'(1);
            if (instret_en) instret_count <= instret_count + XLEN'(1);
        end
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle sequencer for the RV32I core: FETCH -> DECODE -> EXECUTE ->
// [MEM] -> WRITEBACK, with HALT on ECALL/EBREAK/illegal/misaligned target.
// Owns the PC and the instruction register.
// Ports:
//   clk, reset             - core clock, synchronous active-high reset
//   im_req/im_addr         - fetch request at pc, held until im_ready
//   im_ready/im_rdata      - fetch completion and instruction word
//   ir, pc                 - instruction register and its PC
//   dec_*                  - decoder classification of ir
//   jbl_taken/jbl_target   - branch outcome and jump/branch target
//   ex_enable              - ALU/JBL evaluate strobe (EXECUTE)
//   dm_req/dm_ready        - data memory handshake (MEM)
//   rf_write_enable        - gated register-file write (WRITEBACK)
//   retire, halted         - completion pulse, stopped flag
//   trap_cause             - 0 none, 1 ecall, 2 ebreak, 3 illegal, 4 misaligned
//   cycle_count/instret_count - performance counters
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            im_req,
    output logic [XLEN-1:0] im_addr,
    input  logic            im_ready,
    input  logic [XLEN-1:0] im_rdata,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] pc,
    input  logic            dec_is_load,
    input  logic            dec_is_store,
    input  logic            dec_is_jump,
    input  logic            dec_is_branch,
    input  logic            dec_rf_we,
    input  logic            dec_ecall,
    input  logic            dec_ebreak,
    input  logic            dec_illegal,
    input  logic            jbl_taken,
    input  logic [XLEN-1:0] jbl_target,
    output logic            ex_enable,
    output logic            dm_req,
    input  logic            dm_ready,
    output logic            rf_write_enable,
    output logic            retire,
    output logic            halted,
    output logic [2:0]      trap_cause,
    output logic [XLEN-1:0] cycle_count,
    output logic [XLEN-1:0] instret_count
);

    state_t          state, state_next;
    trap_t           trap_q, trap_next;
    logic [XLEN-1:0] pc_q, ir_q, target_q;
    logic            is_load_q, is_store_q, is_jump_q, is_branch_q, rf_we_q;
    logic            redirect_q, redirect_now;

    assign redirect_now = is_jump_q | (is_branch_q & jbl_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            trap_q      <= TRAP_NONE;
            pc_q        <= RESET_VECTOR;
            ir_q        <= '0;
            target_q    <= '0;
            redirect_q  <= 1'b0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_jump_q   <= 1'b0;
            is_branch_q <= 1'b0;
            rf_we_q     <= 1'b0;
        end else begin
            state  <= state_next;
            trap_q <= trap_next;
            case (state)
                ST_FETCH: if (im_ready) ir_q <= im_rdata;
                ST_DECODE: begin
                    is_load_q   <= dec_is_load;
                    is_store_q  <= dec_is_store;
                    is_jump_q   <= dec_is_jump;
                    is_branch_q <= dec_is_branch;
                    rf_we_q     <= dec_rf_we;
                end
                ST_EXECUTE: begin
                    redirect_q <= redirect_now;
                    target_q   <= jbl_target;
                end
                ST_WRITEBACK: pc_q <= redirect_q ? target_q : pc_q + XLEN'(4);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next      = state;
        trap_next       = trap_q;
        im_req          = 1'b0;
        ex_enable       = 1'b0;
        dm_req          = 1'b0;
        rf_write_enable = 1'b0;
        retire          = 1'b0;
        halted          = 1'b0;
        case (state)
            ST_FETCH: begin
                im_req = 1'b1;
                if (im_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_next = ST_HALT;
                    trap_next  = TRAP_ILLEGAL;
                end else if (dec_ecall) begin
                    state_next = ST_HALT;
                    trap_next  = TRAP_ECALL;
                end else if (dec_ebreak) begin
                    state_next = ST_HALT;
                    trap_next  = TRAP_EBREAK;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                ex_enable = 1'b1;
                if (redirect_now && jbl_target[1:0] != 2'b00) begin
                    state_next = ST_HALT;
                    trap_next  = TRAP_MISALIGN;
                end else if (is_load_q || is_store_q) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                dm_req = 1'b1;
                if (dm_ready) state_next = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                // Stores and branches never write rd regardless of the decoder.
                rf_write_enable = rf_we_q & ~is_store_q & ~is_branch_q;
                retire          = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: begin
                // Corrupted state register: stop as if an illegal instruction.
                state_next = ST_HALT;
                trap_next  = TRAP_ILLEGAL;
            end
        endcase
        // The state register may still hold a live state during the reset
        // cycle; keep every strobe quiet until reset is released.
        if (reset) begin
            im_req          = 1'b0;
            ex_enable       = 1'b0;
            dm_req          = 1'b0;
            rf_write_enable = 1'b0;
            retire          = 1'b0;
            halted          = 1'b0;
        end
    end

    assign pc         = pc_q;
    assign im_addr    = pc_q;
    assign ir         = ir_q;
    assign trap_cause = trap_q;

    cpu_perf_counters #(.XLEN(XLEN)) u_perf (
        .clk           (clk),
        .reset         (reset),
        .cycle_en      (state != ST_HALT),
        .instret_en    (retire),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm. The bench plays memory and decoder:
// each instruction is described by its class flags, fetch/data wait counts,
// and branch outcome; a per-instruction timing/outcome model predicts cycles,
// strobe counts, trap cause, PC and counters.
module tb_cpu_control_fsm;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            im_req, im_ready = 1'b0;
    logic [XLEN-1:0] im_addr, im_rdata = '0, ir, pc;
    logic            dec_is_load = 0, dec_is_store = 0, dec_is_jump = 0, dec_is_branch = 0;
    logic            dec_rf_we = 0, dec_ecall = 0, dec_ebreak = 0, dec_illegal = 0;
    logic            jbl_taken = 0;
    logic [XLEN-1:0] jbl_target = '0;
    logic            ex_enable, dm_req, dm_ready = 1'b0;
    logic            rf_write_enable, retire, halted;
    logic [2:0]      trap_cause;
    logic [XLEN-1:0] cycle_count, instret_count;

    cpu_control_fsm #(.XLEN(XLEN), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
        .ir(ir), .pc(pc),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_jump(dec_is_jump),
        .dec_is_branch(dec_is_branch), .dec_rf_we(dec_rf_we), .dec_ecall(dec_ecall),
        .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
        .jbl_taken(jbl_taken), .jbl_target(jbl_target),
        .ex_enable(ex_enable), .dm_req(dm_req), .dm_ready(dm_ready),
        .rf_write_enable(rf_write_enable), .retire(retire), .halted(halted),
        .trap_cause(trap_cause), .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    // Reference state
    logic [31:0] m_pc, m_cycles, m_instret;
    int          last_trap, last_cycles;

    // Current instruction description
    logic        c_ld, c_st, c_jp, c_br, c_we, c_ec, c_eb, c_il, c_tk;
    logic [31:0] c_tg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_instr(input bit ld, st, jp, br, we, ec, eb, il, tk, input logic [31:0] tg);
        c_ld = ld; c_st = st; c_jp = jp; c_br = br; c_we = we;
        c_ec = ec; c_eb = eb; c_il = il; c_tk = tk; c_tg = tg;
    endtask

    // Real decoder flags only in the DECODE cycle; noise otherwise so the
    // sequencer must rely on its latched copy.
    task automatic drive_dec(input bit real_flags);
        if (real_flags) begin
            dec_is_load = c_ld; dec_is_store = c_st; dec_is_jump = c_jp; dec_is_branch = c_br;
            dec_rf_we = c_we; dec_ecall = c_ec; dec_ebreak = c_eb; dec_illegal = c_il;
        end else begin
            {dec_is_load, dec_is_store, dec_is_jump, dec_is_branch} = 4'($urandom);
            {dec_rf_we, dec_ecall, dec_ebreak, dec_illegal} = 4'($urandom);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; im_ready = 1'b1; im_rdata = $urandom; dm_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_ir", ir, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_cycle", cycle_count, 32'h0);
        check("rst_instret", instret_count, 32'h0);
        check("rst_trap", {29'd0, trap_cause}, 32'h0);
        check("rst_strobes", {26'd0, im_req, ex_enable, dm_req, rf_write_enable, retire, halted}, 32'h0);
        reset = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
        m_pc = 32'h0; m_cycles = 32'h0; m_instret = 32'h0;
        #1;
    endtask

    task automatic run_instr(input int imw, input int dmw);
        int cyc = 0, fetch_n = 0, mem_n = 0, ex_n = 0, dm_n = 0, rfw_n = 0, ret_n = 0;
        bit done = 0, dec_next = 0;
        logic [31:0] word = 32'h0;
        int trap, exp_cyc;
        bit redir, ls;
        // Outcome model from the instruction's class
        trap  = c_il ? 3 : c_ec ? 1 : c_eb ? 2 : 0;
        redir = c_jp || (c_br && c_tk);
        ls    = c_ld || c_st;
        if (trap == 0 && redir && c_tg[1:0] != 2'b00) trap = 4;
        exp_cyc = imw + 2;                        // fetch waits + fetch + decode
        if (!(c_il || c_ec || c_eb)) exp_cyc += 1; // execute
        if (trap == 0) exp_cyc += (ls ? dmw + 1 : 0) + 1;

        while (!done && cyc < 100) begin
            if (halted) done = 1;
            else begin
                cyc++;
                drive_dec(dec_next);
                dec_next = 0;
                if (ex_enable) begin
                    ex_n++; jbl_taken = c_tk; jbl_target = c_tg;
                end else begin
                    jbl_taken = 1'($urandom); jbl_target = $urandom;
                end
                im_rdata = $urandom;
                if (im_req) begin
                    check("im_addr", im_addr, m_pc);
                    im_ready = (fetch_n == imw);
                    if (im_ready) begin word = im_rdata; dec_next = 1; end
                    fetch_n++;
                end else im_ready = 1'($urandom);
                if (dm_req) begin
                    dm_n++; dm_ready = (mem_n == dmw); mem_n++;
                end else dm_ready = 1'($urandom);
                if (rf_write_enable) rfw_n++;
                if (retire) begin ret_n++; done = 1; end
            end
            @(posedge clk); #1;
        end

        m_cycles += 32'(exp_cyc);
        if (trap == 0) begin
            m_instret += 1;
            m_pc = redir ? c_tg : m_pc + 32'd4;
        end
        last_trap = trap; last_cycles = cyc;

        check("cycles", 32'(cyc), 32'(exp_cyc));
        check("ex_cnt", 32'(ex_n), (c_il || c_ec || c_eb) ? 32'd0 : 32'd1);
        check("dm_cnt", 32'(dm_n), (trap == 0 && ls) ? 32'(dmw + 1) : 32'd0);
        check("rfw_cnt", 32'(rfw_n), (trap == 0 && c_we && !c_st && !c_br) ? 32'd1 : 32'd0);
        check("retire_cnt", 32'(ret_n), (trap == 0) ? 32'd1 : 32'd0);
        check("halted", {31'd0, halted}, (trap != 0) ? 32'd1 : 32'd0);
        check("trap_cause", {29'd0, trap_cause}, 32'(trap));
        check("ir", ir, word);
        check("pc", pc, m_pc);
        check("cycle_count", cycle_count, m_cycles);
        check("instret", instret_count, m_instret);
    endtask

    task automatic halt_freeze();
        for (int i = 0; i < 4; i++) begin
            im_ready = 1'($urandom); dm_ready = 1'($urandom); im_rdata = $urandom;
            drive_dec(1'b0);
            @(posedge clk); #1;
            check("halt_strobes", {27'd0, im_req, ex_enable, dm_req, rf_write_enable, retire}, 32'h0);
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_cycle", cycle_count, m_cycles);
            check("halt_pc", pc, m_pc);
        end
    endtask

    initial begin
        do_reset();
        do_reset();

        // Straight-line ALU stream
        set_instr(0,0,0,0,1,0,0,0,0, 32'h0);
        for (int i = 0; i < 3; i++) run_instr(0, 0);
        check("alu3_instret", instret_count, 32'd3);
        check("alu3_cycles", cycle_count, 32'd12);
        run_instr(1, 0);
        check("pc_at_lw", pc, 32'h10);

        // LW with 3-cycle data wait
        set_instr(1,0,0,0,1,0,0,0,0, 32'h0);
        run_instr(0, 3);
        check("lw_total", 32'(last_cycles), 32'd8);
        check("lw_pc", pc, 32'h14);

        // BEQ taken / not taken (decoder's rd write must be suppressed)
        set_instr(0,0,0,1,1,0,0,0,1, 32'h40);
        run_instr(0, 0);
        check("beq_taken_pc", pc, 32'h40);
        set_instr(0,0,0,1,0,0,0,0,0, 32'h80);
        run_instr(0, 0);
        check("beq_nt_pc", pc, 32'h44);

        // Store with rf_we asserted by decoder
        set_instr(0,1,0,0,1,0,0,0,0, 32'h0);
        run_instr(2, 1);

        // Reset while in FETCH with im_ready high
        do_reset();

        // JAL to misaligned target
        set_instr(0,0,1,0,1,0,0,0,0, 32'h102);
        run_instr(0, 0);
        check("jal_mis_trap", 32'(last_trap), 32'd4);
        halt_freeze();
        do_reset();

        set_instr(0,0,0,0,0,1,0,0,0, 32'h0);       // ECALL
        run_instr(0, 0);
        halt_freeze();
        do_reset();
        set_instr(0,0,0,0,0,1,0,1,0, 32'h0);       // illegal + ECALL
        run_instr(1, 0);
        do_reset();
        set_instr(0,0,0,0,0,0,1,0,0, 32'h0);       // EBREAK
        run_instr(0, 0);
        do_reset();

        // PC wrap
        set_instr(0,0,1,0,1,0,0,0,0, 32'hFFFF_FFFC);
        run_instr(0, 0);
        set_instr(0,0,0,0,1,0,0,0,0, 32'h0);
        run_instr(0, 0);
        check("pc_wrap", pc, 32'h0);

        // Random instruction mix
        for (int n = 0; n < 200; n++) begin
            int k;
            logic [31:0] tg;
            bit we;
            k  = $urandom_range(0, 19);
            tg = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tg = tg | 32'($urandom_range(1, 3));
            we = 1'($urandom);
            if (k <= 5)       set_instr(0,0,0,0,we,0,0,0,0, tg);
            else if (k <= 8)  set_instr(1,0,0,0,we,0,0,0,0, tg);
            else if (k <= 10) set_instr(0,1,0,0,we,0,0,0,0, tg);
            else if (k <= 13) set_instr(0,0,1,0,we,0,0,0,0, tg);
            else if (k <= 16) set_instr(0,0,0,1,we,0,0,0,1'($urandom), tg);
            else if (k == 17) set_instr(0,0,0,0,we,1,1'($urandom),0,0, tg);
            else if (k == 18) set_instr(0,0,0,0,we,0,1,0,0, tg);
            else              set_instr(0,0,0,0,we,1'($urandom),1'($urandom),1,0, tg);
            run_instr($urandom_range(0, 3), $urandom_range(0, 3));
            if (last_trap != 0) begin
                halt_freeze();
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
